// File: rtl/sample_gain_stage.sv
// Stereo gain/mute stage: ramped Q2.14 gain, saturating multiply, two-stage
// stall-propagating pipeline between the ADC and DAC sample streams.

module sample_gain_lane #(
    parameter int SW    = 24,
    parameter int GW    = 16,
    parameter int SHIFT = 14
) (
    input  logic [SW-1:0] sample_i,
    input  logic [GW-1:0] gain_i,
    output logic [SW-1:0] y_o,
    output logic          sat_o
);
    localparam int PW = SW + GW + 1;
    localparam logic signed [PW-1:0] SMAX = {{(PW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{(PW-SW+1){1'b1}}, {(SW-1){1'b0}}};

    logic signed [PW-1:0] sx, gx, p, r;

    // Product always fits in PW bits, so the truncated signed multiply is exact.
    assign sx = {{(GW+1){sample_i[SW-1]}}, sample_i};
    assign gx = {{SW{1'b0}}, 1'b0, gain_i};
    assign p  = sx * gx;
    assign r  = p >>> SHIFT;

    always_comb begin
        y_o   = r[SW-1:0];
        sat_o = 1'b0;
        if (r > SMAX) begin
            y_o   = SMAX[SW-1:0];
            sat_o = 1'b1;
        end else if (r < SMIN) begin
            y_o   = SMIN[SW-1:0];
            sat_o = 1'b1;
        end
    end
endmodule

module sample_gain_stage #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int GAIN_WIDTH   = 16,
    parameter int RAMP_STEP    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GAIN_WIDTH-1:0]     gain_target,
    input  logic                      mute,
    input  logic [2*SAMPLE_WIDTH-1:0] in_sample_tdata,
    input  logic                      in_sample_tvalid,
    output logic                      in_sample_tready,
    output logic [2*SAMPLE_WIDTH-1:0] out_sample_tdata,
    output logic                      out_sample_tvalid,
    input  logic                      out_sample_tready,
    output logic [GAIN_WIDTH-1:0]     gain_cur,
    output logic                      clip
);
    localparam int SW = SAMPLE_WIDTH;
    localparam int GW = GAIN_WIDTH;
    localparam logic [GW-1:0] STEP = GW'(RAMP_STEP);

    logic                   run_q;
    logic [GW-1:0]          gain_q, gain_d, eff;
    logic                   s1_vld_q, s2_vld_q, s2_clip_q;
    logic [1:0][SW-1:0]     s1_smp_q, s2_smp_q, prod;
    logic [GW-1:0]          s1_gain_q;
    logic [1:0]             sat;
    logic                   s2_adv, s1_adv, in_acc;

    // run_q keeps tready low while reset is held and for the first edge after.
    assign s2_adv           = !s2_vld_q || out_sample_tready;
    assign s1_adv           = !s1_vld_q || s2_adv;
    assign in_sample_tready = run_q && s1_adv;
    assign in_acc           = in_sample_tvalid && in_sample_tready;

    assign eff = mute ? '0 : gain_target;

    always_comb begin
        gain_d = gain_q;
        if (in_acc) begin
            if (eff > gain_q)
                gain_d = (eff - gain_q > STEP) ? gain_q + STEP : eff;
            else
                gain_d = (gain_q - eff > STEP) ? gain_q - STEP : eff;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_lane
        sample_gain_lane #(.SW(SW), .GW(GW), .SHIFT(14)) u_lane (
            .sample_i (s1_smp_q[ch]),
            .gain_i   (s1_gain_q),
            .y_o      (prod[ch]),
            .sat_o    (sat[ch])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= 1'b0;
            gain_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_smp_q  <= '0;
            s1_gain_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_smp_q  <= '0;
            s2_clip_q <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            gain_q <= gain_d;
            if (s1_adv) begin
                s1_vld_q <= in_acc;
                if (in_acc) begin
                    s1_smp_q  <= in_sample_tdata;
                    s1_gain_q <= gain_d;
                end
            end
            if (s2_adv) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_smp_q  <= prod;
                    s2_clip_q <= |sat;
                end
            end
        end
    end

    assign out_sample_tdata  = s2_smp_q;
    assign out_sample_tvalid = s2_vld_q;
    assign gain_cur          = gain_q;
    assign clip              = s2_vld_q && out_sample_tready && s2_clip_q;
endmodule

// File: tb/tb_sample_gain_stage.sv
// Scoreboard bench for sample_gain_stage: driver pushes expected beats,
// monitor pops and compares on every output transfer.

module tb_sample_gain_stage;
    logic        clk, reset;
    logic [15:0] gain_target;
    logic        mute;
    logic [47:0] in_tdata, out_tdata;
    logic        in_tvalid, in_tready, out_tvalid, out_tready;
    logic [15:0] gain_cur;
    logic        clip;

    sample_gain_stage #(.SAMPLE_WIDTH(24), .GAIN_WIDTH(16), .RAMP_STEP(16)) dut (
        .clk(clk), .reset(reset), .gain_target(gain_target), .mute(mute),
        .in_sample_tdata(in_tdata), .in_sample_tvalid(in_tvalid),
        .in_sample_tready(in_tready), .out_sample_tdata(out_tdata),
        .out_sample_tvalid(out_tvalid), .out_sample_tready(out_tready),
        .gain_cur(gain_cur), .clip(clip));

    typedef struct { logic [47:0] data; bit c; } exp_t;
    exp_t sb[$];

    int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
    int mg = 0;
    int rdy_mode = 0;
    bit lat_arm = 0, first_pend = 1;
    bit prev_stall = 0;
    logic [47:0] prev_data;

    initial begin clk = 0; forever #5 clk = ~clk; end
    initial forever begin @(posedge clk); cyc++; end

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0: out_tready = 1'b1;
            1: out_tready = 1'($urandom_range(0, 1));
            default: out_tready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_beat(input logic [23:0] s, input int g,
                                       output logic [23:0] y, output bit c);
        longint p, r;
        p = longint'($signed(s)) * longint'(g);
        r = p >>> 14;
        c = 0;
        if (r > 64'sd8388607) begin r = 8388607; c = 1; end
        else if (r < -64'sd8388608) begin r = -8388608; c = 1; end
        y = r[23:0];
    endfunction

    // Monitor
    initial forever begin
        @(negedge clk);
        if (!reset) prev_stall = 0;
        else begin
            if (prev_stall && out_tvalid) chk("hold_data", out_tdata, prev_data);
            if (lat_arm && out_tvalid) begin
                chk("latency", cyc - acc_cyc, 2);
                lat_arm = 0;
            end
            if (out_tvalid && out_tready) begin
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_tdata, e.data);
                    chk("clip", clip, e.c);
                end
            end else if (out_tvalid) chk("clip_stalled", clip, 0);
            prev_stall = out_tvalid && !out_tready;
            prev_data  = out_tdata;
        end
    end

    task automatic send(input logic [23:0] l, input logic [23:0] r, input bit hand,
                        input logic [23:0] hl, input logic [23:0] hr, input bit hc);
        exp_t e;
        int eff;
        logic [23:0] yl, yr;
        bit cl, cr;
        in_tvalid = 1; in_tdata = {l, r};
        for (int w = 0; ; w++) begin
            @(negedge clk);
            if (in_tready) break;
            if (w > 200) begin
                $display("FAIL accept_timeout: tready stuck low (t=%0t)", $time);
                bad++; total++;
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1);
            end
            @(posedge clk); #1;
        end
        eff = mute ? 0 : int'(gain_target);
        if (eff > mg) mg = (eff - mg > 16) ? mg + 16 : eff;
        else          mg = (mg - eff > 16) ? mg - 16 : eff;
        model_beat(l, mg, yl, cl);
        model_beat(r, mg, yr, cr);
        e.data = hand ? {hl, hr} : {yl, yr};
        e.c    = hand ? hc : (cl | cr);
        sb.push_back(e);
        if (first_pend) begin acc_cyc = cyc; lat_arm = 1; first_pend = 0; end
        @(posedge clk); #1;
        chk("gain_cur", gain_cur, mg);
    endtask

    task automatic drain();
        in_tvalid = 0;
        for (int w = 0; w < 3000 && sb.size() != 0; w++) begin @(posedge clk); #2; end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        reset = 0; gain_target = 16'h4000; mute = 0;
        in_tvalid = 0; in_tdata = '0; out_tready = 1;
        #2;
        chk("rst_tvalid", out_tvalid, 0);
        chk("rst_tdata", out_tdata, 0);
        chk("rst_tready", in_tready, 0);
        chk("rst_gain", gain_cur, 0);
        chk("rst_clip", clip, 0);
        #10 reset = 1;
        @(posedge clk); #1;

        // Soft start to unity, then exact pass-through
        for (int i = 0; i < 1024; i++) send(24'h100000, 24'hF00000, 0, 0, 0, 0);
        chk("unity_reached", gain_cur, 16'h4000);
        for (int i = 0; i < 6; i++) send(24'h100000, 24'hF00000, 1, 24'h100000, 24'hF00000, 0);

        // Gain 2.0 saturates both rails
        gain_target = 16'h8000;
        for (int i = 0; i < 1024; i++) send(24'h7FFFFF, 24'h800000, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) send(24'h7FFFFF, 24'h800000, 1, 24'h7FFFFF, 24'h800000, 1);

        // Half gain: truncation toward -inf
        gain_target = 16'h2000;
        for (int i = 0; i < 1536; i++) send(24'h000003, 24'hFFFFFD, 0, 0, 0, 0);
        chk("half_reached", gain_cur, 16'h2000);
        for (int i = 0; i < 3; i++) send(24'h000003, 24'hFFFFFD, 1, 24'h000001, 24'hFFFFFE, 0);

        // Back to unity with random backpressure, counting pattern
        rdy_mode = 1;
        gain_target = 16'h4000;
        for (int i = 0; i < 512; i++) send(24'(i), 24'(-i), 0, 0, 0, 0);
        for (int i = 0; i < 500; i++) send(24'(i * 3 + 1), 24'(-i), 1, 24'(i * 3 + 1), 24'(-i), 0);
        drain();
        rdy_mode = 0;

        // Mute ramps to zero, unmute ramps back
        mute = 1;
        for (int i = 0; i < 1024; i++) send(24'h123456, 24'hEDCBA9, 0, 0, 0, 0);
        chk("mute_gain", gain_cur, 0);
        send(24'h123456, 24'hEDCBA9, 1, 24'h0, 24'h0, 0);
        mute = 0;
        for (int i = 0; i < 1024; i++) send(24'h123456, 24'hEDCBA9, 0, 0, 0, 0);
        chk("unmute_gain", gain_cur, 16'h4000);
        send(24'h123456, 24'hEDCBA9, 1, 24'h123456, 24'hEDCBA9, 0);
        drain();

        // Reset with both stages full
        rdy_mode = 2;
        @(posedge clk); #1;
        send(24'h0AAAAA, 24'h055555, 0, 0, 0, 0);
        send(24'h0BBBBB, 24'h066666, 0, 0, 0, 0);
        #3;
        chk("full_tvalid", out_tvalid, 1);
        reset = 0;
        #1;
        chk("mid_rst_tvalid", out_tvalid, 0);
        chk("mid_rst_tready", in_tready, 0);
        chk("mid_rst_gain", gain_cur, 0);
        chk("mid_rst_tdata", out_tdata, 0);
        sb.delete();
        mg = 0;
        in_tvalid = 0;
        #10 reset = 1;
        rdy_mode = 0;
        first_pend = 1;
        @(posedge clk); #1;
        send(24'h400000, 24'hC00000, 1, 24'h001000, 24'hFFF000, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sample_gain_stage.md
Name: sample_gain_stage

Overview:
- Stereo gain/mute stage on the codec sample path.
- Consumes stereo beats from the i2s_serdes ADC stream (adc_sample) and produces beats for the i2s_serdes DAC stream (dac_sample).
- Applies a ramped (click-free) fixed-point gain with saturation.
- Flags clipping to the control/status logic.

Parameters:
- SAMPLE_WIDTH, 24, signed two's-complement width of one channel sample.
- GAIN_WIDTH, 16, unsigned gain width, Q2.14 format (0x4000 = unity, 0xFFFF ≈ 3.9999).
- RAMP_STEP, 16, maximum change of the applied gain per accepted input beat.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- gain_target  input  GAIN_WIDTH  requested gain, Q2.14; sampled every cycle.
- mute  input  1  1 forces the effective target to 0; ramps like any gain change.
- in_sample  Axis_If.Slave  —  tdata[2*SAMPLE_WIDTH-1:0] = {left, right}; uses tvalid and tready.
- out_sample  Axis_If.Master  —  same packing; uses tvalid and tready.
- gain_cur  output  GAIN_WIDTH  gain currently applied (status).
- clip  output  1  one-cycle pulse on an output beat transfer where either channel saturated.

Behaviour:
Reset (reset=0, asynchronous):
- out_sample.tvalid=0, out_sample.tdata=0, in_sample.tready=0 during reset, gain_cur=0, clip=0.
- All pipeline valid bits are cleared; in-flight samples are discarded, not flushed.
- After release, gain_cur ramps from 0 toward the target, giving a soft start.

Effective target:
- eff = mute ? 0 : gain_target.

Ramp:
- Occurs on each in_sample transfer (tvalid & tready), before that beat is multiplied.
- If |eff − gain_cur| ≤ RAMP_STEP: gain_cur ← eff.
- Else gain_cur moves RAMP_STEP toward eff.
- gain_cur never overshoots eff.
- The beat that triggers the ramp uses the updated gain.
- No ramp occurs while no beats are accepted.
- A target change mid-ramp redirects the ramp from the current gain_cur.

Pipeline:
- S1 registers {left, right, gain}.
- S2 registers the saturated products and the clip bit.
- Full throughput: 1 beat per cycle.
- Latency: 2 cycles from in_sample transfer to out_sample.tvalid when the output is unstalled.
- in_sample.tready = !S2_valid | out_sample.tready | !S1_valid. This is a stall-propagating pipeline; no combinational path from in_sample.tvalid to out_sample.tvalid.
- A stage advances only when its successor is empty or draining.
- While out_sample.tvalid=1 and tready=0, out_sample.tdata is held stable.
- No beat is lost or duplicated under any tready pattern.

Arithmetic, per channel:
- p = sample (signed SAMPLE_WIDTH) × gain (unsigned, zero-extended), full precision SAMPLE_WIDTH+GAIN_WIDTH+1 bits.
- r = p >>> 14, arithmetic shift, truncation toward −inf.
- Saturate r to [−2^(SAMPLE_WIDTH−1), 2^(SAMPLE_WIDTH−1)−1].
- clip_bit = saturation occurred on left or right.

clip:
- Asserted for exactly the cycle in which an out_sample transfer carries clip_bit=1.
- Not asserted while stalled.

Simultaneous events:
- mute and a gain_target change in the same cycle: mute wins, eff=0.
- Input accept and output drain in the same cycle with both stages full: both occur, and occupancy is unchanged.

Test Plan:
- Reset release, gain_target=0x4000, RAMP_STEP=16, continuous input {0x100000, 0xF00000} → gain_cur reaches 0x4000 after exactly 1024 accepted beats; outputs thereafter equal inputs exactly; output valid 2 cycles after first accept.
- Unity gain reached, left=0x7FFFFF, right=0x800000, gain_target=0x8000 (after ramp) → output {0x7FFFFF, 0x800000} saturated; clip pulses once per output beat.
- gain_target=0x2000 (0.5), left=0x000003, right=0xFFFFFD → output {0x000001, 0xFFFFFE}, confirming truncation toward −inf.
- Random out_sample.tready (50%) with a counting input pattern of 500 beats at unity gain → output sequence identical and in order, no drops or duplicates; tdata stable while stalled.
- At unity gain, assert mute → gain_cur decreases by 16 per accepted beat to 0 (1024 beats), output → 0. Deassert mute → ramps back to 0x4000.
- reset asserted mid-stream with both stages full → out_sample.tvalid drops immediately (asynchronously); first output after release is a newly accepted beat, gain_cur restarts ramp from 0.
